// File: rtl/irq_source_ctrl_pkg.sv
// irq_pkg: shared channel indices and default widths for the CP0 interrupt source block.
package irq_pkg;
    localparam int IRQ_NUM      = 3;
    localparam int IRQ_CH_TIMER = 0;
    localparam int IRQ_CH_BTN0  = 1;
    localparam int IRQ_CH_BTN1  = 2;
    localparam int DEBOUNCE_W   = 16;
    localparam int TIMER_W      = 32;
    typedef logic [IRQ_NUM-1:0] irq_vec_t;
endpackage

// File: rtl/irq_source_ctrl_if.sv
// irq_source_ctrl_if: control/request bundle between the handler side (master) and irq_source_ctrl (slave).
interface irq_source_ctrl_if #(parameter int TIMER_WIDTH = irq_pkg::TIMER_W);
    import irq_pkg::*;
    logic [1:0]             btn;
    logic                   timer_load;
    logic [TIMER_WIDTH-1:0] timer_din;
    logic                   timer_en;
    irq_vec_t               ack;
    irq_vec_t               intsrc;
    logic [TIMER_WIDTH-1:0] timer_count;
    modport master (output btn, timer_load, timer_din, timer_en, ack, input intsrc, timer_count);
    modport slave  (input btn, timer_load, timer_din, timer_en, ack, output intsrc, timer_count);
endinterface

// File: rtl/irq_source_ctrl_debouncer.sv
// irq_debouncer: 2-FF synchronizer, stability counter and press (0->1) event for one raw button.
module irq_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_event
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          r_stable_d;
    logic          w_done;
    assign w_done = r_cnt == CW'(DEBOUNCE_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], i_btn};
            r_stable_d <= r_stable;
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    // Only presses matter; releases fall through silently.
    assign o_event = r_stable & ~r_stable_d;
endmodule

// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: periodic timer + two debounced buttons feeding CP0 intsrc[2:0] with ack-cleared pending bits.
// Define IRQ_PULSE_EN to drive intsrc as one-cycle event pulses instead of pending levels.
module irq_source_ctrl
    import irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMER_WIDTH     = TIMER_W
) (
    input logic               clk,
    input logic               rst_n,
    irq_source_ctrl_if.slave  bus
);
    logic [TIMER_WIDTH-1:0] r_reload;
    logic [TIMER_WIDTH-1:0] r_count;
    logic [TIMER_WIDTH-1:0] w_count_nxt;
    irq_vec_t               r_pending;
    irq_vec_t               w_event;
    logic                   w_tick;
    irq_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (bus.btn[0]),
        .o_event (w_event[IRQ_CH_BTN0])
    );
    irq_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (bus.btn[1]),
        .o_event (w_event[IRQ_CH_BTN1])
    );
    // A load in the same cycle wins over counting, so it also suppresses the expiry event.
    assign w_tick                = bus.timer_en && (r_reload != '0) && !bus.timer_load;
    assign w_event[IRQ_CH_TIMER] = w_tick && (r_count == TIMER_WIDTH'(1));
    always_comb begin
        w_count_nxt = bus.timer_load ? bus.timer_din :
                      !w_tick                         ? r_count :
                      (r_count <= TIMER_WIDTH'(1))    ? r_reload :
                                                        r_count - 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reload  <= '0;
            r_count   <= '0;
            r_pending <= '0;
        end else begin
            if (bus.timer_load) r_reload <= bus.timer_din;
            r_count   <= w_count_nxt;
            r_pending <= (r_pending & ~bus.ack) | w_event;
        end
    end
`ifdef IRQ_PULSE_EN
    irq_vec_t r_pulse;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pulse <= '0;
        else        r_pulse <= w_event;
    end
    assign bus.intsrc = r_pulse;
`else
    assign bus.intsrc = r_pending;
`endif
    assign bus.timer_count = r_count;
endmodule
